// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding
// and the fixed constants used by the datapath.
package div_pkg;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] DZ_QUOT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_32_seq_if.sv
// Start/done handshake bundle between the ALU (master) and the divider (slave).
interface div_32_seq_if;
    import div_pkg::*;

    logic                start;
    logic [DIV_ITER-1:0] dividend;
    logic [DIV_ITER-1:0] divisor;
    logic [DIV_ITER-1:0] quotient;
    logic [DIV_ITER-1:0] remainder;
    logic                busy;
    logic                done;
    logic                div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/sub_32.sv
// 32-bit subtractor: diff = a - b, carry_out = 1 when no borrow (a >= b).
module sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        carry_out
);

    assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;

endmodule

// File: rtl/div_32_seq.sv
// Sequential 32-bit unsigned restoring divider, one trial subtraction per
// clock through sub_32, with a start/done handshake towards the ALU.
module div_32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    div_32_seq_if.slave   bus
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  dvsr_q, dvsr_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH-1:0]  rs;
    logic              msb;
    logic [WIDTH-1:0]  diff;
    logic              carry_out;
    logic              take;
    logic [WIDTH-1:0]  r_next;
    logic [WIDTH-1:0]  q_next;

    // The 33rd bit of the shifted remainder lives only in msb; when it is set
    // the true value exceeds any divisor and the mod-2^32 difference is exact.
    assign msb    = r_q[WIDTH-1];
    assign rs     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign take   = msb | carry_out;
    assign r_next = take ? diff : rs;
    assign q_next = {q_q[WIDTH-2:0], take};

    sub_32 u_sub (
        .a         (rs),
        .b         (dvsr_q),
        .diff      (diff),
        .carry_out (carry_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Q doubles as the captured dividend for the divide-by-zero path.
                    dvsr_d  = bus.divisor;
                    q_d     = bus.dividend;
                    r_d     = '0;
                    cnt_d   = CNT_W'(DIV_ITER - 1);
                    dbz_d   = 1'b0;
                    state_d = (bus.divisor == '0) ? DZ : RUN;
                end
            end
            RUN: begin
                r_d = r_next;
                q_d = q_next;
                if (cnt_q == '0) begin
                    quot_d  = q_next;
                    rem_d   = r_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DZ: begin
                quot_d  = DZ_QUOT;
                rem_d   = q_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// Directed and randomized bench for div_32_seq against an arithmetic reference.
module tb_div_32_seq;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_fail;

    div_32_seq_if dif ();

    div_32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        int          e;
        ref_div(a, b, eq, er);
        start_op(a, b);
        check({tag, "_busy_on_accept"}, 32'(dif.busy), 32'd1);
        check({tag, "_dbz_cleared"}, 32'(dif.div_by_zero), 32'd0);
        wait_done(e);
        check({tag, "_latency"}, 32'(e), (b == 32'd0) ? 32'd1 : 32'd32);
        check({tag, "_quotient"}, dif.quotient, eq);
        check({tag, "_remainder"}, dif.remainder, er);
        check({tag, "_dbz"}, 32'(dif.div_by_zero), (b == 32'd0) ? 32'd1 : 32'd0);
        check({tag, "_busy_at_done"}, 32'(dif.busy), 32'd0);
    endtask

    initial begin
        int          e;
        logic [31:0] a, b;
        n_pass       = 0;
        n_total      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", dif.quotient, 32'd0);
        check("rst_remainder", dif.remainder, 32'd0);
        check("rst_busy_done_dbz", {29'd0, dif.busy, dif.done, dif.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 56/3, then 2/1 issued in the done cycle of the first.
        do_div("d56_3", 32'h38, 32'h3);
        do_div("d2_1_b2b", 32'd2, 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(dif.done), 32'd0);

        do_div("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0001);
        do_div("dmax_1", 32'hFFFF_FFFF, 32'h1);
        do_div("dz", 32'h1234, 32'h0);
        do_div("d10_3_after_dz", 32'd10, 32'd3);

        // Start pulsed mid-way through 100/7 must be ignored.
        start_op(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = 32'd7;
        dif.divisor  = 32'd2;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        check("ign_busy", 32'(dif.busy), 32'd1);
        wait_done(e);
        check("ign_latency", 32'(e), 32'd21);
        check("ign_quotient", dif.quotient, 32'd14);
        check("ign_remainder", dif.remainder, 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("ign_single_done", 32'(dif.done), 32'd0);
        end

        // Asynchronous reset between edges during iteration 10 of 100/7.
        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_quotient", dif.quotient, 32'd0);
        check("arst_remainder", dif.remainder, 32'd0);
        check("arst_busy_done_dbz", {29'd0, dif.busy, dif.done, dif.div_by_zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_no_done", 32'(dif.done), 32'd0);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            check("arst_idle_no_done", {30'd0, dif.busy, dif.done}, 32'd0);
        end
        do_div("d9_4_after_rst", 32'd9, 32'd4);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = $urandom_range(1, 15);
                default: b = (i % 4 == 0) ? 32'd0 : $urandom_range(0, 255);
            endcase
            do_div($sformatf("rand%0d", i), a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
